// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: shares one RAM port between fetch and LSU with data priority and bounded fetch starvation
package riscv_mem_arbiter_pkg;
  typedef enum logic [1:0] {MASK_B = 2'd0, MASK_H = 2'd1, MASK_X = 2'd2} mask_sel_t;
endpackage

module riscv_mem_arbiter
  import riscv_mem_arbiter_pkg::*;
#(
  parameter int WORD_LENGTH  = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   if_req,
  input  logic [WORD_LENGTH-1:0] if_addr,
  output logic                   if_gnt,
  output logic                   if_rvalid,
  output logic [WORD_LENGTH-1:0] if_rdata,
  output logic                   if_err,
  input  logic                   ls_req,
  input  logic [WORD_LENGTH-1:0] ls_addr,
  input  logic                   ls_we,
  input  logic [WORD_LENGTH-1:0] ls_wdata,
  input  mask_sel_t              ls_mask_sel,
  output logic                   ls_gnt,
  output logic                   ls_rvalid,
  output logic [WORD_LENGTH-1:0] ls_rdata,
  output logic                   ls_err,
  output logic [WORD_LENGTH-1:0] mem_addr,
  output logic                   mem_we,
  output logic [WORD_LENGTH-1:0] mem_wdata,
  output mask_sel_t              mem_mask_sel,
  input  logic [WORD_LENGTH-1:0] mem_rdata
);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt, starve_nxt;
  logic fetch_turn, if_mis, ls_mis;
  always_comb begin
    fetch_turn   = starve_cnt == LIMIT;
    ls_gnt       = rst_n & ls_req & (~if_req | ~fetch_turn);
    if_gnt       = rst_n & if_req & (~ls_req | fetch_turn);
    if_mis       = |if_addr[1:0];
    ls_mis       = (ls_mask_sel == MASK_H && ls_addr[0]) || (ls_mask_sel == MASK_X && |ls_addr[1:0]);
    starve_nxt   = (!if_req || if_gnt) ? 4'd0 :
                   ls_gnt ? (fetch_turn ? starve_cnt : starve_cnt + 4'd1) : starve_cnt;
    mem_addr     = if_gnt ? if_addr : ls_gnt ? ls_addr : '0;
    mem_we       = ls_gnt & ls_we & ~ls_mis;
    mem_wdata    = ls_gnt ? ls_wdata : '0;
    mem_mask_sel = ls_gnt ? ls_mask_sel : MASK_X;
  end
  // responses are rebuilt every cycle, so an idle cycle naturally clears rvalid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      if_rvalid  <= 1'b0;
      if_rdata   <= '0;
      if_err     <= 1'b0;
      ls_rvalid  <= 1'b0;
      ls_rdata   <= '0;
      ls_err     <= 1'b0;
    end else begin
      starve_cnt <= starve_nxt;
      if_rvalid  <= if_gnt;
      if_rdata   <= (if_gnt && !if_mis) ? mem_rdata : '0;
      if_err     <= if_gnt & if_mis;
      ls_rvalid  <= ls_gnt;
      ls_rdata   <= (ls_gnt && !ls_we && !ls_mis) ? mem_rdata : '0;
      ls_err     <= ls_gnt & ls_mis;
    end
  end
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb_riscv_mem_arbiter: directed scoreboard bench with a byte-maskable RAM model
module tb_riscv_mem_arbiter;
  import riscv_mem_arbiter_pkg::*;
  logic clk = 0, rst_n = 0;
  logic if_req = 0, if_gnt, if_rvalid, if_err;
  logic [31:0] if_addr = 0, if_rdata;
  logic ls_req = 0, ls_we = 0, ls_gnt, ls_rvalid, ls_err, mem_we;
  logic [31:0] ls_addr = 0, ls_wdata = 0, ls_rdata, mem_addr, mem_wdata, mem_rdata;
  mask_sel_t ls_mask_sel = MASK_X, mem_mask_sel;
  logic [31:0] ram [64];
  typedef struct { bit port; logic [31:0] rdata; bit err; } rsp_t;
  rsp_t q[$];
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  riscv_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .ls_req(ls_req), .ls_addr(ls_addr), .ls_we(ls_we), .ls_wdata(ls_wdata), .ls_mask_sel(ls_mask_sel),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_mask_sel(mem_mask_sel), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = ram[mem_addr[7:2]];
  always @(posedge clk)
    if (mem_we) begin
      if (mem_mask_sel == MASK_B) ram[mem_addr[7:2]][{mem_addr[1:0], 3'b000} +: 8] <= mem_wdata[7:0];
      else if (mem_mask_sel == MASK_H) ram[mem_addr[7:2]][{mem_addr[1], 4'b0000} +: 16] <= mem_wdata[15:0];
      else ram[mem_addr[7:2]] <= mem_wdata;
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic check_rsp();
    rsp_t r;
    if (q.size() > 0) begin
      r = q.pop_front();
      if (r.port) begin
        chk("ls_rvalid", ls_rvalid, 1);
        chk("ls_rdata", ls_rdata, r.rdata);
        chk("ls_err", ls_err, r.err);
        chk("if_rvalid_idle", if_rvalid, 0);
      end else begin
        chk("if_rvalid", if_rvalid, 1);
        chk("if_rdata", if_rdata, r.rdata);
        chk("if_err", if_err, r.err);
        chk("ls_rvalid_idle", ls_rvalid, 0);
      end
    end else begin
      chk("if_rvalid_none", if_rvalid, 0);
      chk("ls_rvalid_none", ls_rvalid, 0);
    end
  endtask

  task automatic step(input bit ir, input logic [31:0] ia, input bit lr, input bit lw, input logic [31:0] la,
                      input logic [31:0] ld, input mask_sel_t lm, input bit eig, input bit elg);
    bit mis;
    @(posedge clk); #1;
    if_req = ir; if_addr = ia; ls_req = lr; ls_we = lw; ls_addr = la; ls_wdata = ld; ls_mask_sel = lm;
    @(negedge clk);
    check_rsp();
    chk("if_gnt", if_gnt, eig);
    chk("ls_gnt", ls_gnt, elg);
    mis = (lm == MASK_H && la[0]) || (lm == MASK_X && la[1:0] != 2'b00);
    chk("mem_we", mem_we, elg & lw & ~mis);
    if (eig) q.push_back('{0, (ia[1:0] != 0) ? 32'h0 : ram[ia[7:2]], ia[1:0] != 0});
    if (elg) q.push_back('{1, (lw || mis) ? 32'h0 : ram[la[7:2]], mis});
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, MASK_X, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 32'h1000_0000 + i;
    ram[4] = 32'hDEAD_BEEF;
    if_req = 1; ls_req = 1; ls_we = 1; ls_addr = 32'h30;
    #12;
    chk("rst_if_gnt", if_gnt, 0);
    chk("rst_ls_gnt", ls_gnt, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_ls_rvalid", ls_rvalid, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_ls_err", ls_err, 0);
    if_req = 0; ls_req = 0; ls_we = 0;
    @(posedge clk); #1 rst_n = 1;
    // single fetch
    step(1, 32'h10, 0, 0, 0, 0, MASK_X, 1, 0);
    idle();
    chk("fetch_word", if_rdata, 32'hDEAD_BEEF);
    // contention: L,L,L,L,I repeated
    for (int i = 0; i < 15; i++) begin
      step(1, 32'h80 + 32'(4 * (i / 5)), 1, 0, 32'h40 + 32'(4 * i), 0, MASK_X, i % 5 == 4, i % 5 != 4);
      if (i % 5 == 0) chk("starve_cnt_zero", dut.starve_cnt, 0);
    end
    idle();
    // byte store then word load
    step(0, 0, 1, 1, 32'h21, 32'h0000_00AB, MASK_B, 0, 1);
    chk("mem_mask_b", mem_mask_sel, MASK_B);
    step(0, 0, 1, 0, 32'h20, 0, MASK_X, 0, 1);
    idle();
    chk("byte_lane", ls_rdata[15:8], 8'hAB);
    // misaligned store, fetch, half load; then aligned half store and readback
    step(0, 0, 1, 1, 32'h22, 32'hFFFF_FFFF, MASK_X, 0, 1);
    step(1, 32'h13, 0, 0, 0, 0, MASK_X, 1, 0);
    step(0, 0, 1, 0, 32'h21, 0, MASK_H, 0, 1);
    step(0, 0, 1, 1, 32'h42, 32'h1234_5678, MASK_H, 0, 1);
    step(0, 0, 1, 0, 32'h40, 0, MASK_X, 0, 1);
    idle();
    chk("ram_unchanged", ram[8], 32'h1000_AB08);
    chk("half_store", ls_rdata, 32'h5678_0010);
    // reset while a load response is outstanding
    step(0, 0, 1, 0, 32'h10, 0, MASK_X, 0, 1);
    @(posedge clk); #1;
    rst_n = 0; if_req = 1; ls_req = 1; ls_we = 1; ls_addr = 32'h30; ls_mask_sel = MASK_X;
    #1;
    chk("mid_rst_ls_rvalid", ls_rvalid, 0);
    chk("mid_rst_if_rvalid", if_rvalid, 0);
    chk("mid_rst_if_gnt", if_gnt, 0);
    chk("mid_rst_ls_gnt", ls_gnt, 0);
    chk("mid_rst_mem_we", mem_we, 0);
    q.delete();
    if_req = 0; ls_req = 0; ls_we = 0;
    @(posedge clk); #1 rst_n = 1;
    step(1, 32'h10, 0, 0, 0, 0, MASK_X, 1, 0);
    idle();
    // counter clears when fetch withdraws
    step(1, 32'h14, 1, 0, 32'h50, 0, MASK_X, 0, 1);
    step(1, 32'h14, 1, 0, 32'h54, 0, MASK_X, 0, 1);
    step(0, 32'h14, 1, 0, 32'h58, 0, MASK_X, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 32'h14, 1, 0, 32'h60 + 32'(4 * i), 0, MASK_X, i == 4, i != 4);
    idle();
    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end
endmodule
